sub1_frame_feed: RTL and testbench
==================================

Name: sub1_frame_feed

Overview:
- Byte-stream-to-frame packer placed directly upstream of sub1.
- Collects bytes from a valid/ready byte source into 3-byte frames.
- Drives sub1's input group: frame strobe, valid-byte count, current frame as a packed array, previous frame as an unpacked array.
- Partial frames are emitted on an explicit flush or after an idle timeout, with unused slots padded.

Parameters:
- TIMEOUT, 16, idle cycles in COLLECT with no accepted byte before a partial frame is emitted; 0 disables the timeout.
- PAD, 8'h00, fill value for unfilled slots of a partial frame.

Ports:
- clk  input  1  block clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- i_en  input  1  enable; low stalls intake and freezes the timeout counter.
- i_byte_vld  input  1  byte valid from source.
- i_byte  input  8  byte data.
- o_byte_rdy  output  1  ready to source; combinational, equal to i_en.
- i_flush  input  1  single-cycle request to emit any partial frame.
- o_sig_a  output  1  frame strobe, one cycle per emitted frame (to sub1 i_sig_a).
- o_sig_b  output  2  valid byte count of the last frame, 1..3 (to sub1 i_sig_b).
- o_sig_c  output  [0:2][7:0]  current frame, packed; slot 0 = first byte (to sub1 i_sig_c).
- o_sig_d  output  [7:0] x [0:2]  previous frame, unpacked (to sub1 i_sig_d).
- o_frame_cnt  output  8  count of emitted frames, wraps 255->0.

Behaviour:
- Reset (async assert, sync release): all outputs 0 (o_sig_a, o_sig_b, all o_sig_c and o_sig_d elements, o_frame_cnt); assembly buffer cleared; byte count = 0; FSM = IDLE; timer = 0.
- Reset mid-frame discards the partial frame; no strobe is produced.
- Accept condition: i_byte_vld && o_byte_rdy. An accepted byte is written to assembly slot[cnt], then cnt increments.
- FSM:
  - IDLE (cnt=0): an accept moves to COLLECT.
  - COLLECT (cnt 1..2): the third accept triggers a full emit and returns to IDLE. A flush or timeout triggers a partial emit and returns to IDLE.
- Emit, registered at the edge after the triggering cycle (latency 1 from the 3rd-byte accept):
  - o_sig_a = 1 for exactly one cycle.
  - o_sig_c = assembly slots, with unfilled slots = PAD.
  - o_sig_b = number of valid bytes.
  - o_sig_d[k] = old o_sig_c[k] for k = 0..2.
  - o_frame_cnt increments.
  - Assembly buffer and cnt cleared in the same edge.
- Between strobes, o_sig_b/c/d hold their values.
- Zero-bubble: ready stays high across an emit. A byte accepted in the cycle after the 3rd byte starts the next frame at slot 0.
- Timer:
  - Width $clog2(TIMEOUT+1).
  - Counts cycles in COLLECT with i_en=1 and no accept; reset to 0 on every accept and on every emit.
  - Timeout fires when timer == TIMEOUT-1 and there is no accept that cycle.
- Simultaneous events:
  - Flush + accept in the same cycle: the byte is included, then the frame is emitted (count includes it).
  - 3rd-byte accept + flush or timeout: a single full emit, o_sig_b = 3.
  - Flush with cnt=0 and no accept: ignored, no strobe.
- i_en=0: no accepts, timer frozen, flush still honoured.
- o_sig_b = 0 only between reset and the first emit.

Test Plan:
- Reset release, i_en=1, send 8'h11, 8'h22, 8'h33 on consecutive cycles -> one cycle after the 3rd accept: o_sig_a=1, o_sig_c={11,22,33}, o_sig_b=3, o_sig_d={0,0,0}, o_frame_cnt=1.
- Continuous stream 11..66 (six bytes, back-to-back) -> strobes 3 cycles apart. Second frame: o_sig_c={44,55,66}, o_sig_d={11,22,33}, o_frame_cnt=2; o_byte_rdy never low.
- Send 8'hAA then idle, TIMEOUT=16, PAD=8'h00 -> strobe exactly 16 idle cycles after the accept, o_sig_c={AA,00,00}, o_sig_b=1. A byte arriving after 15 idle cycles restarts the timer instead.
- Send 8'h01, then 8'h02 together with i_flush -> single strobe, o_sig_c={01,02,00}, o_sig_b=2. A later lone i_flush with cnt=0 -> no strobe.
- Send 2 bytes, assert rst_n=0 for 1 cycle -> all outputs 0, no strobe. Next 3 bytes 07,08,09 -> o_sig_c={07,08,09}, o_frame_cnt=1.
- Emit 256 frames -> o_frame_cnt wraps to 0. i_en=0 with i_byte_vld=1 for 40 cycles -> o_byte_rdy=0, no accept, no timeout strobe.

Source files
------------

// File: rtl/sub1_frame_feed.sv
`default_nettype none
// ============================================================================
// Module      : sub1_frame_feed
// Description : Packs a valid/ready byte stream into 3-byte frames for sub1.
//               Emits a one-cycle strobe with the current frame (packed), the
//               previous frame (unpacked) and the valid-byte count. Partial
//               frames go out on flush or after an idle timeout, padded.
// Revision    : 1.0 - initial release
// ============================================================================
module sub1_frame_feed #(
    parameter int         TIMEOUT = 16,
    parameter logic [7:0] PAD     = 8'h00
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_en,
    input  logic            i_byte_vld,
    input  logic [7:0]      i_byte,
    output logic            o_byte_rdy,
    input  logic            i_flush,
    output logic            o_sig_a,
    output logic [1:0]      o_sig_b,
    output logic [0:2][7:0] o_sig_c,
    output logic [7:0]      o_sig_d [0:2],
    output logic [7:0]      o_frame_cnt
);

    // A zero TIMEOUT would otherwise give a zero-width timer.
    localparam int c_TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(TIMEOUT - 1);
    localparam bit c_TMO_EN = (TIMEOUT > 0);

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_COLLECT = 1'b1;

    logic [0:0]         r_state;
    logic [1:0]         r_cnt;
    logic [0:2][7:0]    r_asm;
    logic [c_TMR_W-1:0] r_timer;

    logic               w_accept;
    logic               w_full;
    logic               w_flush_emit;
    logic               w_timeout;
    logic               w_emit;
    logic [1:0]         w_count;
    logic [0:2][7:0]    w_frame;

    // Ready simply follows enable, so the source is never stalled by an emit.
    assign o_byte_rdy   = i_en;
    assign w_accept     = i_byte_vld && i_en;
    assign w_full       = w_accept && (r_cnt == 2'd2);
    // A flush only matters if there is (or is about to be) a byte to send.
    assign w_flush_emit = i_flush && ((r_cnt != 2'd0) || w_accept);
    assign w_timeout    = c_TMO_EN && (r_state == ST_COLLECT) && i_en &&
                          !w_accept && (r_timer == c_TMR_LAST);
    assign w_emit       = w_full || w_flush_emit || w_timeout;
    assign w_count      = r_cnt + {1'b0, w_accept};

    // Frame to emit: stored slots, plus this cycle's byte, padding the rest.
    always_comb begin
        w_frame = {3{PAD}};
        for (int k = 0; k < 3; k++) begin
            if (2'(k) < r_cnt) begin
                w_frame[k] = r_asm[k];
            end else if (w_accept && (2'(k) == r_cnt)) begin
                w_frame[k] = i_byte;
            end
        end
    end

    // Assembly, FSM, idle timer and registered sub1 outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 2'd0;
            r_asm       <= '0;
            r_timer     <= '0;
            o_sig_a     <= 1'b0;
            o_sig_b     <= 2'd0;
            o_sig_c     <= '0;
            o_frame_cnt <= 8'd0;
            for (int k = 0; k < 3; k++) begin
                o_sig_d[k] <= 8'd0;
            end
        end else if (w_emit) begin
            o_sig_a     <= 1'b1;
            o_sig_b     <= w_count;
            o_sig_c     <= w_frame;
            o_frame_cnt <= o_frame_cnt + 8'd1;
            for (int k = 0; k < 3; k++) begin
                o_sig_d[k] <= o_sig_c[k];
            end
            r_state <= ST_IDLE;
            r_cnt   <= 2'd0;
            r_asm   <= '0;
            r_timer <= '0;
        end else begin
            o_sig_a <= 1'b0;
            if (w_accept) begin
                r_asm[r_cnt] <= i_byte;
                r_cnt        <= r_cnt + 2'd1;
                r_state      <= ST_COLLECT;
                r_timer      <= '0;
            end else if ((r_state == ST_COLLECT) && i_en) begin
                r_timer <= r_timer + c_TMR_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sub1_frame_feed.sv
`default_nettype none
// ============================================================================
// Module      : tb_sub1_frame_feed
// Description : Directed self-checking bench for sub1_frame_feed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sub1_frame_feed;

    logic            clk;
    logic            rst_n;
    logic            i_en;
    logic            i_byte_vld;
    logic [7:0]      i_byte;
    logic            o_byte_rdy;
    logic            i_flush;
    logic            o_sig_a;
    logic [1:0]      o_sig_b;
    logic [0:2][7:0] o_sig_c;
    logic [7:0]      o_sig_d [0:2];
    logic [7:0]      o_frame_cnt;

    int checks   = 0;
    int failures = 0;

    sub1_frame_feed #(.TIMEOUT(16), .PAD(8'h00)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_en       (i_en),
        .i_byte_vld (i_byte_vld),
        .i_byte     (i_byte),
        .o_byte_rdy (o_byte_rdy),
        .i_flush    (i_flush),
        .o_sig_a    (o_sig_a),
        .o_sig_b    (o_sig_b),
        .o_sig_c    (o_sig_c),
        .o_sig_d    (o_sig_d),
        .o_frame_cnt(o_frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock edge; outputs are examined 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        i_byte_vld = 1'b1;
        i_byte     = b;
        step();
        i_byte_vld = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    function automatic logic [31:0] sig_c24();
        return {8'h00, o_sig_c[0], o_sig_c[1], o_sig_c[2]};
    endfunction

    function automatic logic [31:0] sig_d24();
        return {8'h00, o_sig_d[0], o_sig_d[1], o_sig_d[2]};
    endfunction

    initial begin
        logic strobe_seen;
        logic rdy_low;
        rst_n      = 1'b0;
        i_en       = 1'b1;
        i_byte_vld = 1'b0;
        i_byte     = 8'h00;
        i_flush    = 1'b0;

        // Reset state
        step();
        step();
        chk("rst_a",   {31'd0, o_sig_a}, 32'd0);
        chk("rst_b",   {30'd0, o_sig_b}, 32'd0);
        chk("rst_c",   sig_c24(), 32'd0);
        chk("rst_d",   sig_d24(), 32'd0);
        chk("rst_cnt", {24'd0, o_frame_cnt}, 32'd0);
        chk("rst_rdy", {31'd0, o_byte_rdy}, 32'd1);
        rst_n = 1'b1;
        step();

        // First full frame
        i_byte_vld = 1'b1;
        i_byte = 8'h11; step();
        chk("f1_nostrobe1", {31'd0, o_sig_a}, 32'd0);
        i_byte = 8'h22; step();
        chk("f1_nostrobe2", {31'd0, o_sig_a}, 32'd0);
        i_byte = 8'h33; step();
        i_byte_vld = 1'b0;
        chk("f1_a",   {31'd0, o_sig_a}, 32'd1);
        chk("f1_c",   sig_c24(), 32'h112233);
        chk("f1_b",   {30'd0, o_sig_b}, 32'd3);
        chk("f1_d",   sig_d24(), 32'd0);
        chk("f1_cnt", {24'd0, o_frame_cnt}, 32'd1);
        step();
        chk("f1_a_drop", {31'd0, o_sig_a}, 32'd0);
        chk("f1_c_hold", sig_c24(), 32'h112233);

        // Back-to-back stream of six bytes
        do_reset();
        for (int i = 0; i < 6; i++) begin
            i_byte_vld = 1'b1;
            i_byte     = 8'h11 * (i + 1);
            chk("s_rdy", {31'd0, o_byte_rdy}, 32'd1);
            step();
            chk("s_strobe", {31'd0, o_sig_a}, (i == 2 || i == 5) ? 32'd1 : 32'd0);
        end
        i_byte_vld = 1'b0;
        chk("s_c",   sig_c24(), 32'h445566);
        chk("s_d",   sig_d24(), 32'h112233);
        chk("s_cnt", {24'd0, o_frame_cnt}, 32'd2);

        // Idle timeout with one byte
        do_reset();
        send(8'hAA);
        strobe_seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step();
            strobe_seen |= o_sig_a;
        end
        chk("to_early", {31'd0, strobe_seen}, 32'd0);
        step();
        chk("to_a", {31'd0, o_sig_a}, 32'd1);
        chk("to_c", sig_c24(), 32'hAA0000);
        chk("to_b", {30'd0, o_sig_b}, 32'd1);

        // Byte in the last idle cycle restarts the timer
        send(8'hAA);
        strobe_seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step();
            strobe_seen |= o_sig_a;
        end
        send(8'hBB);
        strobe_seen |= o_sig_a;
        for (int i = 0; i < 15; i++) begin
            step();
            strobe_seen |= o_sig_a;
        end
        chk("tr_early", {31'd0, strobe_seen}, 32'd0);
        step();
        chk("tr_a", {31'd0, o_sig_a}, 32'd1);
        chk("tr_c", sig_c24(), 32'hAABB00);
        chk("tr_b", {30'd0, o_sig_b}, 32'd2);
        chk("tr_cnt", {24'd0, o_frame_cnt}, 32'd2);

        // Flush together with the second byte
        do_reset();
        send(8'h01);
        i_flush = 1'b1;
        send(8'h02);
        i_flush = 1'b0;
        chk("fl_a", {31'd0, o_sig_a}, 32'd1);
        chk("fl_c", sig_c24(), 32'h010200);
        chk("fl_b", {30'd0, o_sig_b}, 32'd2);
        step();
        chk("fl_single", {31'd0, o_sig_a}, 32'd0);
        i_flush = 1'b1;
        step();
        i_flush = 1'b0;
        chk("fl_empty", {31'd0, o_sig_a}, 32'd0);
        step();
        chk("fl_empty2", {31'd0, o_sig_a}, 32'd0);
        chk("fl_cnt", {24'd0, o_frame_cnt}, 32'd1);

        // Reset mid-frame, then a fresh frame
        send(8'h07);
        send(8'h08);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_b",   {30'd0, o_sig_b}, 32'd0);
        chk("mr_c",   sig_c24(), 32'd0);
        chk("mr_cnt", {24'd0, o_frame_cnt}, 32'd0);
        step();
        rst_n = 1'b1;
        chk("mr_a", {31'd0, o_sig_a}, 32'd0);
        send(8'h07);
        send(8'h08);
        send(8'h09);
        chk("mr2_a",   {31'd0, o_sig_a}, 32'd1);
        chk("mr2_c",   sig_c24(), 32'h070809);
        chk("mr2_d",   sig_d24(), 32'd0);
        chk("mr2_cnt", {24'd0, o_frame_cnt}, 32'd1);

        // 256 frames wrap the frame counter
        do_reset();
        i_byte_vld = 1'b1;
        for (int f = 0; f < 256; f++) begin
            for (int j = 0; j < 3; j++) begin
                i_byte = 8'(f * 3 + j);
                step();
            end
            if (f == 254) chk("wr_255", {24'd0, o_frame_cnt}, 32'd255);
        end
        i_byte_vld = 1'b0;
        chk("wr_0", {24'd0, o_frame_cnt}, 32'd0);
        chk("wr_c", sig_c24(), 32'hFDFEFF);

        // Enable low: no intake, timer frozen, flush still honoured
        do_reset();
        send(8'hCC);
        i_en = 1'b0;
        i_byte_vld = 1'b1;
        i_byte = 8'h5A;
        strobe_seen = 1'b0;
        rdy_low = 1'b1;
        for (int i = 0; i < 40; i++) begin
            rdy_low &= ~o_byte_rdy;
            step();
            strobe_seen |= o_sig_a;
        end
        chk("en_rdy", {31'd0, rdy_low}, 32'd1);
        chk("en_nostrobe", {31'd0, strobe_seen}, 32'd0);
        i_byte_vld = 1'b0;
        i_flush = 1'b1;
        step();
        i_flush = 1'b0;
        chk("en_fl_a", {31'd0, o_sig_a}, 32'd1);
        chk("en_fl_c", sig_c24(), 32'hCC0000);
        chk("en_fl_b", {30'd0, o_sig_b}, 32'd1);
        i_en = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
